// File: rtl/ram_slave_gen.sv
// Single-port inferred RAM behind a simple valid/mode bus with configurable read latency and write wait.
// Define RAM_SLAVE_GEN_CLR_EN to zero the whole memory after every reset release.
module ram_slave_gen #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    DEPTH_LOG2 = 14,
  parameter int                    RD_LATENCY = 1,
  parameter int                    WR_WAIT    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] BUS_addr,
  input  logic [DATA_WIDTH-1:0] BUS_wdata,
  output logic [DATA_WIDTH-1:0] BUS_rdata,
  input  logic                  BUS_valid,
  input  logic                  BUS_mode,
  output logic                  BUS_wready,
  output logic                  BUS_rvalid,
  input  logic                  BUS_rready
);

  localparam int DEPTH     = 2 ** DEPTH_LOG2;
  localparam int BYTE_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam int SPAN_LOG2 = BYTE_LOG2 + DEPTH_LOG2;

  typedef enum logic [2:0] {IDLE, WRITE, RWAIT, RDATA, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    wready_q, wready_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rd_word_q;
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0]   offset;
  logic                    hit;
  logic [DEPTH_LOG2-1:0]   word_idx;
  logic                    mem_we;
  logic                    mem_re;
  logic [DEPTH_LOG2-1:0]   mem_widx;
  logic [DATA_WIDTH-1:0]   mem_wdata;

`ifdef RAM_SLAVE_GEN_CLR_EN
  logic [DEPTH_LOG2-1:0]   clr_idx_q, clr_idx_d;
  logic                    clr_pend_q, clr_pend_d;
`endif

  // The upper-bound test on the offset avoids overflow of BASE_ADDR + size.
  assign offset   = BUS_addr - BASE_ADDR;
  assign hit      = (BUS_addr >= BASE_ADDR) && ((offset >> SPAN_LOG2) == '0);
  assign word_idx = DEPTH_LOG2'(offset >> BYTE_LOG2);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wready_d  = 1'b0;
    rvalid_d  = rvalid_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_widx  = word_idx;
    mem_wdata = BUS_wdata;
`ifdef RAM_SLAVE_GEN_CLR_EN
    clr_idx_d  = clr_idx_q;
    clr_pend_d = clr_pend_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef RAM_SLAVE_GEN_CLR_EN
        if (clr_pend_q) begin
          state_d    = CLEAR;
          clr_pend_d = 1'b0;
          clr_idx_d  = '0;
        end else
`endif
        if (BUS_valid && hit) begin
          if (BUS_mode) begin
            mem_we   = 1'b1;
            state_d  = WRITE;
            cnt_d    = 2'(WR_WAIT);
            wready_d = (WR_WAIT == 0);
          end else begin
            mem_re = 1'b1;
            if (RD_LATENCY == 1) begin
              state_d  = RDATA;
              rvalid_d = 1'b1;
            end else begin
              state_d = RWAIT;
              cnt_d   = 2'(RD_LATENCY - 1);
            end
          end
        end
      end
      WRITE: begin
        if (wready_q) begin
          state_d = IDLE;
        end else begin
          cnt_d    = cnt_q - 2'd1;
          wready_d = (cnt_q == 2'd1);
        end
      end
      RWAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d  = RDATA;
          rvalid_d = 1'b1;
        end
      end
      RDATA: begin
        if (BUS_rready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      CLEAR: begin
`ifdef RAM_SLAVE_GEN_CLR_EN
        mem_we    = 1'b1;
        mem_widx  = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wready_q <= 1'b0;
      rvalid_q <= 1'b0;
`ifdef RAM_SLAVE_GEN_CLR_EN
      clr_idx_q  <= '0;
      clr_pend_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wready_q <= wready_d;
      rvalid_q <= rvalid_d;
`ifdef RAM_SLAVE_GEN_CLR_EN
      clr_idx_q  <= clr_idx_d;
      clr_pend_q <= clr_pend_d;
`endif
    end
  end

  // Memory is never reset; the read register only loads on a read accept, so it stays stable in RDATA.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_widx] <= mem_wdata;
    if (rst_n && mem_re) rd_word_q <= mem[word_idx];
  end

  assign BUS_wready = wready_q;
  assign BUS_rvalid = rvalid_q;
  assign BUS_rdata  = rvalid_q ? rd_word_q : '0;

endmodule

// File: tb/tb_ram_slave_gen.sv
// Randomized self-checking bench for ram_slave_gen: three differently configured instances checked
// against a word-array reference model with bus timing derived from the latency/wait parameters.
module tb_ram_slave_gen;

  localparam int N = 3;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h1000_0000;
  localparam logic [31:0] BASE2 = 32'h0000_0100;
  localparam int DL0 = 6, DL1 = 4, DL2 = 5;
  localparam int LAT0 = 1, LAT1 = 3, LAT2 = 4;
  localparam int WW0 = 0, WW1 = 2, WW2 = 1;

  logic        clk = 1'b0;
  logic        rst_n  [N];
  logic [31:0] addr   [N];
  logic [31:0] wdata  [N];
  logic [31:0] rdata  [N];
  logic        valid  [N];
  logic        mode   [N];
  logic        wready [N];
  logic        rvalid [N];
  logic        rready [N];

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [N][64];

  always #5 clk = ~clk;

  ram_slave_gen #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(BASE0), .DEPTH_LOG2(DL0),
                  .RD_LATENCY(LAT0), .WR_WAIT(WW0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .BUS_addr(addr[0]), .BUS_wdata(wdata[0]), .BUS_rdata(rdata[0]),
    .BUS_valid(valid[0]), .BUS_mode(mode[0]), .BUS_wready(wready[0]), .BUS_rvalid(rvalid[0]),
    .BUS_rready(rready[0]));

  ram_slave_gen #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(BASE1), .DEPTH_LOG2(DL1),
                  .RD_LATENCY(LAT1), .WR_WAIT(WW1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .BUS_addr(addr[1]), .BUS_wdata(wdata[1]), .BUS_rdata(rdata[1]),
    .BUS_valid(valid[1]), .BUS_mode(mode[1]), .BUS_wready(wready[1]), .BUS_rvalid(rvalid[1]),
    .BUS_rready(rready[1]));

  ram_slave_gen #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(BASE2), .DEPTH_LOG2(DL2),
                  .RD_LATENCY(LAT2), .WR_WAIT(WW2)) dut2 (
    .clk(clk), .rst_n(rst_n[2]), .BUS_addr(addr[2]), .BUS_wdata(wdata[2]), .BUS_rdata(rdata[2]),
    .BUS_valid(valid[2]), .BUS_mode(mode[2]), .BUS_wready(wready[2]), .BUS_rvalid(rvalid[2]),
    .BUS_rready(rready[2]));

  function automatic logic [31:0] base_of(input int d);
    case (d)
      0: return BASE0;
      1: return BASE1;
      default: return BASE2;
    endcase
  endfunction

  function automatic int words_of(input int d);
    case (d)
      0: return 1 << DL0;
      1: return 1 << DL1;
      default: return 1 << DL2;
    endcase
  endfunction

  function automatic int lat_of(input int d);
    case (d)
      0: return LAT0;
      1: return LAT1;
      default: return LAT2;
    endcase
  endfunction

  function automatic int ww_of(input int d);
    case (d)
      0: return WW0;
      1: return WW1;
      default: return WW2;
    endcase
  endfunction

  // Byte address of word w with random ignored low byte bits.
  function automatic logic [31:0] hit_addr(input int d, input int w);
    return base_of(d) + 32'(w * 4) + 32'($urandom_range(0, 3));
  endfunction

  function automatic int word_of(input int d, input logic [31:0] a);
    return int'((a - base_of(d)) >> 2);
  endfunction

  // Random request traffic while the slave is busy; all of it must be ignored.
  task automatic noise(input int d, input bit noisy);
    if (noisy) begin
      valid[d] = 1'($urandom);
      mode[d]  = 1'($urandom);
      addr[d]  = hit_addr(d, int'($urandom_range(0, words_of(d) - 1)));
      wdata[d] = $urandom;
    end else begin
      valid[d] = 1'b0;
    end
  endtask

  task automatic bus_write(input int d, input logic [31:0] a, input logic [31:0] data, input bit noisy);
    logic exp_w;
    valid[d] = 1'b1; mode[d] = 1'b1; addr[d] = a; wdata[d] = data;
    model[d][word_of(d, a)] = data;
    for (int n = 1; n <= ww_of(d) + 1; n++) begin
      @(negedge clk);
      noise(d, noisy);
      exp_w = (n == ww_of(d) + 1);
      vectors++;
      if (wready[d] !== exp_w || rvalid[d] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL write_timing dut%0d addr=%h T+%0d: wready=%b rvalid=%b, required wready=%b rvalid=0",
                 d, a, n, wready[d], rvalid[d], exp_w);
      end
    end
    @(negedge clk);
    valid[d] = 1'b0;
    vectors++;
    if (wready[d] !== 1'b0 || rvalid[d] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL write_end dut%0d addr=%h: wready=%b rvalid=%b, required 0 0", d, a, wready[d], rvalid[d]);
    end
  endtask

  task automatic bus_read(input int d, input logic [31:0] a, input int hold, input bit noisy);
    logic [31:0] exp_d;
    logic        exp_v;
    valid[d] = 1'b1; mode[d] = 1'b0; addr[d] = a; rready[d] = 1'b0;
    for (int n = 1; n <= lat_of(d); n++) begin
      @(negedge clk);
      noise(d, noisy);
      exp_v = (n == lat_of(d));
      exp_d = exp_v ? model[d][word_of(d, a)] : 32'h0;
      vectors++;
      if (rvalid[d] !== exp_v || rdata[d] !== exp_d || wready[d] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL read_latency dut%0d addr=%h T+%0d: rvalid=%b rdata=%h wready=%b, required rvalid=%b rdata=%h wready=0",
                 d, a, n, rvalid[d], rdata[d], wready[d], exp_v, exp_d);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      noise(d, noisy);
      vectors++;
      if (rvalid[d] !== 1'b1 || rdata[d] !== model[d][word_of(d, a)]) begin
        miscompares++;
        $display("[TB] FAIL read_hold dut%0d addr=%h hold %0d: rvalid=%b rdata=%h, required 1 %h",
                 d, a, h, rvalid[d], rdata[d], model[d][word_of(d, a)]);
      end
    end
    rready[d] = 1'b1;
    @(negedge clk);
    rready[d] = 1'b0;
    valid[d]  = 1'b0;
    vectors++;
    if (rvalid[d] !== 1'b0 || rdata[d] !== 32'h0 || wready[d] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL read_release dut%0d addr=%h: rvalid=%b rdata=%h wready=%b, required 0 0 0",
               d, a, rvalid[d], rdata[d], wready[d]);
    end
  endtask

  task automatic bus_miss(input int d, input logic [31:0] a);
    valid[d] = 1'b1; mode[d] = 1'($urandom); addr[d] = a; wdata[d] = $urandom;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      vectors++;
      if (wready[d] !== 1'b0 || rvalid[d] !== 1'b0 || rdata[d] !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL miss dut%0d addr=%h cycle %0d: wready=%b rvalid=%b rdata=%h, required all 0",
                 d, a, n, wready[d], rvalid[d], rdata[d]);
      end
    end
    valid[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < N; d++) begin
      rst_n[d] = 1'b0; valid[d] = 1'b1; mode[d] = 1'b0; rready[d] = 1'b0;
      addr[d] = base_of(d); wdata[d] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      vectors++;
      if (wready[d] !== 1'b0 || rvalid[d] !== 1'b0 || rdata[d] !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_state dut%0d: wready=%b rvalid=%b rdata=%h, required all 0",
                 d, wready[d], rvalid[d], rdata[d]);
      end
      valid[d] = 1'b0;
      rst_n[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < N; d++)
      for (int w = 0; w < words_of(d); w++) bus_write(d, hit_addr(d, w), $urandom, 1'b0);
  endtask

  task automatic test_write_read();
    bus_write(0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    bus_read(0, 32'h10, 0, 1'b0);
    bus_write(2, BASE2 + 32'h10, 32'h1234_5678, 1'b0);
    bus_read(2, BASE2 + 32'h10, 1, 1'b0);
  endtask

  task automatic test_read_hold();
    bus_write(1, BASE1 + 32'h10, 32'hCAFE_F00D, 1'b0);
    bus_read(1, BASE1 + 32'h10, 5, 1'b0);
  endtask

  task automatic test_decode();
    bus_write(1, 32'h1000_003C, 32'hA5A5_0F0F, 1'b0);
    bus_write(1, 32'h1000_0000, 32'h0000_1111, 1'b0);
    bus_miss(1, 32'h1000_0040);
    bus_miss(1, 32'h0FFF_FFFC);
    bus_miss(2, BASE2 - 32'h4);
    bus_miss(2, BASE2 + 32'h80);
    bus_read(1, 32'h1000_003C, 0, 1'b0);
    bus_read(1, 32'h1000_0000, 0, 1'b0);
    bus_read(2, BASE2, 0, 1'b0);
    bus_read(2, BASE2 + 32'h7C, 0, 1'b0);
  endtask

  task automatic test_alias_busy();
    valid[0] = 1'b1; mode[0] = 1'b1; addr[0] = 32'h13; wdata[0] = 32'h0BAD_F00D;
    model[0][4] = 32'h0BAD_F00D;
    @(negedge clk);
    wdata[0] = 32'h5555_AAAA;
    vectors++;
    if (wready[0] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL alias_wready dut0: wready=%b, required 1", wready[0]);
    end
    @(negedge clk);
    valid[0] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      vectors++;
      if (wready[0] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL alias_second_wready dut0 cycle %0d: wready=%b, required 0", n, wready[0]);
      end
      @(negedge clk);
    end
    bus_read(0, 32'h10, 0, 1'b0);
  endtask

  task automatic test_reset_in_flight();
    logic [31:0] a;
    a = hit_addr(2, 7);
    bus_write(2, a, 32'h7777_0007, 1'b0);
    valid[2] = 1'b1; mode[2] = 1'b0; addr[2] = a;
    @(negedge clk);
    valid[2] = 1'b0; rst_n[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    for (int n = 0; n < 8; n++) begin
      vectors++;
      if (rvalid[2] !== 1'b0 || rdata[2] !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_abort_read dut2 cycle %0d: rvalid=%b rdata=%h, required 0 0", n, rvalid[2], rdata[2]);
      end
      @(negedge clk);
    end
    bus_read(2, a, 0, 1'b0);
    a = hit_addr(1, 9);
    valid[1] = 1'b1; mode[1] = 1'b1; addr[1] = a; wdata[1] = 32'h9999_1234;
    model[1][9] = 32'h9999_1234;
    @(negedge clk);
    valid[1] = 1'b0; rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      vectors++;
      if (wready[1] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_abort_write dut1 cycle %0d: wready=%b, required 0", n, wready[1]);
      end
      @(negedge clk);
    end
    bus_read(1, a, 0, 1'b0);
  endtask

  task automatic test_reset_preserves();
    for (int d = 0; d < N; d++) rst_n[d] = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < N; d++) rst_n[d] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < N; d++)
      for (int k = 0; k < 4; k++)
        bus_read(d, hit_addr(d, int'($urandom_range(0, words_of(d) - 1))), 0, 1'b0);
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 150; i++) begin
      d = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 1) == 1)
        bus_write(d, hit_addr(d, int'($urandom_range(0, words_of(d) - 1))), $urandom, 1'b1);
      else
        bus_read(d, hit_addr(d, int'($urandom_range(0, words_of(d) - 1))), int'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int i = 0; i < 20; i++) begin
      a = hit_addr(0, int'($urandom_range(0, words_of(0) - 1)));
      bus_write(0, a, $urandom, 1'b0);
      bus_read(0, a, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_hold();
    test_decode();
    test_alias_busy();
    test_reset_in_flight();
    test_reset_preserves();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
